// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: display value, decoder loop and board pins of the 7-segment scan controller
// master: datapath/board side (drives value, load, digit_en, seg_in)
// slave : scan controller (drives hex_out, digitselect, segments, frame_done)
interface seg7_scan_ctrl_if;
  logic [31:0] value;
  logic        load;
  logic [7:0]  digit_en;
  logic [3:0]  hex_out;
  logic [7:0]  seg_in;
  logic [7:0]  digitselect;
  logic [7:0]  segments;
  logic        frame_done;
  modport master(output value, load, digit_en, seg_in, input hex_out, digitselect, segments, frame_done);
  modport slave(input value, load, digit_en, seg_in, output hex_out, digitselect, segments, frame_done);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed 8-digit 7-segment scanner sharing one hex decoder
// Ports: clk, reset (sync, active-high), bus (seg7_scan_ctrl_if.slave):
//   value/load -> pending buffer, digit_en per-digit enable, hex_out/seg_in decoder loop,
//   digitselect/segments active-low registered pins, frame_done boundary pulse.
// Option: define LEADING_ZERO_BLANK_EN to darken leading-zero digits (digit 0 always shown).
module seg7_scan_ctrl #(
  parameter int PRESCALE_BITS = 17,
  parameter int GUARD_CYCLES  = 4096
) (
  input logic             clk,
  input logic             reset,
  seg7_scan_ctrl_if.slave bus
);
  typedef enum logic {GUARD, SHOW} phase_t;
  phase_t                   phase_q, phase_d;
  logic [PRESCALE_BITS-1:0] cnt_q, cnt_d;
  logic [2:0]               idx_q, idx_d;
  logic [31:0]              disp_q, disp_d, pend_q, pend_d;
  logic                     pflag_q, pflag_d;
  logic [7:0]               ds_q, ds_d, seg_q, seg_d;
  logic                     wrap, boundary, blank, vis;
  always_comb begin
    wrap     = &cnt_q;
    boundary = wrap && idx_q == 3'd7;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q + {2'b00, wrap};
    // phase register tracks cnt exactly, so it is derived from the next count
    phase_d  = (cnt_d < PRESCALE_BITS'(GUARD_CYCLES)) ? GUARD : SHOW;
    pend_d   = bus.load ? bus.value : pend_q;
    // a load on the boundary bypasses the pending buffer
    pflag_d  = bus.load ? !boundary : (boundary ? 1'b0 : pflag_q);
    disp_d   = (bus.load && boundary) ? bus.value : (boundary && pflag_q) ? pend_q : disp_q;
`ifdef LEADING_ZERO_BLANK_EN
    blank    = idx_q != 3'd0 && (disp_q >> {idx_q, 2'b00}) == 32'd0;
`else
    blank    = 1'b0;
`endif
    vis      = phase_q == SHOW && bus.digit_en[idx_q] && !blank;
    ds_d     = vis ? ~(8'b1 << idx_q) : 8'hFF;
    seg_d    = vis ? bus.seg_in : 8'hFF;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= GUARD;
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      ds_q    <= 8'hFF;
      seg_q   <= 8'hFF;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      ds_q    <= ds_d;
      seg_q   <= seg_d;
    end
  end
  assign bus.hex_out     = disp_q[{idx_q, 2'b00} +: 4];
  assign bus.digitselect = ds_q;
  assign bus.segments    = seg_q;
  assign bus.frame_done  = boundary;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: table-driven check of scan timing, buffering, masking and reset
module tb_seg7_scan_ctrl;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;
  seg7_scan_ctrl_if bus();
  seg7_scan_ctrl #(.PRESCALE_BITS(3), .GUARD_CYCLES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] dec(input logic [3:0] h);
    logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[h];
  endfunction
  assign bus.seg_in = dec(bus.hex_out);
  typedef struct {
    logic [7:0] en;
    int         off;
    logic [7:0] ds;
    logic [7:0] seg;
    logic [3:0] hex;
  } vec_t;
  vec_t tbl [15];
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic sync_fd();
    int k = 0;
    while (!bus.frame_done && k < 200) begin
      step(1);
      k++;
    end
    chk("frame_done_seen", {31'd0, bus.frame_done}, 32'd1);
  endtask
  task automatic pulse_load(input logic [31:0] v);
    bus.value = v;
    bus.load  = 1'b1;
    step(1);
    bus.load  = 1'b0;
  endtask
  task automatic frame_lit(input string nm, input logic [7:0] exp);
    logic [7:0] lit = 8'h00;
    step(1);
    for (int i = 0; i < 64; i++) begin
      step(1);
      lit |= ~bus.digitselect;
    end
    chk(nm, {24'd0, lit}, {24'd0, exp});
  endtask
  initial begin
    tbl[0]  = '{8'hFF, 2,  8'hFF, 8'hFF, 4'h0};
    tbl[1]  = '{8'hFF, 3,  8'hFF, 8'hFF, 4'h0};
    tbl[2]  = '{8'hFF, 4,  8'hFE, 8'hC0, 4'h0};
    tbl[3]  = '{8'hFF, 9,  8'hFE, 8'hC0, 4'h1};
    tbl[4]  = '{8'hFF, 10, 8'hFF, 8'hFF, 4'h1};
    tbl[5]  = '{8'hFF, 12, 8'hFD, 8'hF9, 4'h1};
    tbl[6]  = '{8'hFF, 20, 8'hFB, 8'hA4, 4'h2};
    tbl[7]  = '{8'hFF, 28, 8'hF7, 8'hB0, 4'h3};
    tbl[8]  = '{8'hFF, 58, 8'hFF, 8'hFF, 4'h7};
    tbl[9]  = '{8'hFF, 60, 8'h7F, 8'hF8, 4'h7};
    tbl[10] = '{8'hF5, 4,  8'hFE, 8'hC0, 4'h0};
    tbl[11] = '{8'hF5, 12, 8'hFF, 8'hFF, 4'h1};
    tbl[12] = '{8'hF5, 20, 8'hFB, 8'hA4, 4'h2};
    tbl[13] = '{8'hF5, 28, 8'hFF, 8'hFF, 4'h3};
    tbl[14] = '{8'hF5, 36, 8'hEF, 8'h99, 4'h4};
    reset = 1'b1;
    bus.value = '0;
    bus.load = 1'b0;
    bus.digit_en = 8'hFF;
    step(2);
    chk("rst_digitselect", {24'd0, bus.digitselect}, 32'hFF);
    chk("rst_segments", {24'd0, bus.segments}, 32'hFF);
    chk("rst_hex_out", {28'd0, bus.hex_out}, 32'h0);
    chk("rst_frame_done", {31'd0, bus.frame_done}, 32'h0);
    reset = 1'b0;
    pulse_load(32'h76543210);
    for (int i = 0; i < 15; i++) begin
      bus.digit_en = tbl[i].en;
      sync_fd();
      step(tbl[i].off);
      chk($sformatf("vec%0d_ds", i), {24'd0, bus.digitselect}, {24'd0, tbl[i].ds});
      chk($sformatf("vec%0d_seg", i), {24'd0, bus.segments}, {24'd0, tbl[i].seg});
      chk($sformatf("vec%0d_hex", i), {28'd0, bus.hex_out}, {28'd0, tbl[i].hex});
    end
    begin
      int viol = 0;
      sync_fd();
      for (int i = 0; i < 64; i++) begin
        step(1);
        if (bus.digitselect == 8'hFD || bus.digitselect == 8'hF7) viol++;
      end
      chk("mask_never_fd_f7", viol, 0);
    end
    bus.digit_en = 8'hFF;
    begin
      int k = 1;
      sync_fd();
      step(1);
      while (!bus.frame_done && k < 200) begin
        step(1);
        k++;
      end
      chk("frame_period", k, 64);
    end
    sync_fd();
    step(20);
    pulse_load(32'hDEADBEEF);
    step(23);
    chk("dbuf_old_hex", {28'd0, bus.hex_out}, 32'h5);
    chk("dbuf_old_ds", {24'd0, bus.digitselect}, 32'hDF);
    chk("dbuf_old_seg", {24'd0, bus.segments}, 32'h92);
    sync_fd();
    chk("dbuf_boundary_hex", {28'd0, bus.hex_out}, 32'h7);
    step(1);
    chk("dbuf_new_hex", {28'd0, bus.hex_out}, 32'hF);
    step(3);
    chk("dbuf_new_ds", {24'd0, bus.digitselect}, 32'hFE);
    chk("dbuf_new_seg", {24'd0, bus.segments}, 32'h8E);
    sync_fd();
    step(10);
    pulse_load(32'h00000005);
    sync_fd();
    pulse_load(32'h0000000A);
    chk("bload_hex", {28'd0, bus.hex_out}, 32'hA);
    step(3);
    chk("bload_ds", {24'd0, bus.digitselect}, 32'hFE);
    chk("bload_seg", {24'd0, bus.segments}, 32'h88);
    sync_fd();
    step(1);
    chk("bload_stale_dropped", {28'd0, bus.hex_out}, 32'hA);
    sync_fd();
    step(10);
    pulse_load(32'h12345678);
    step(33);
    reset = 1'b1;
    step(1);
    chk("mrst_ds", {24'd0, bus.digitselect}, 32'hFF);
    chk("mrst_seg", {24'd0, bus.segments}, 32'hFF);
    chk("mrst_hex", {28'd0, bus.hex_out}, 32'h0);
    reset = 1'b0;
    sync_fd();
    step(4);
    chk("mrst_after_hex", {28'd0, bus.hex_out}, 32'h0);
    chk("mrst_after_seg", {24'd0, bus.segments}, 32'hC0);
    sync_fd();
    step(1);
    chk("mrst_pend_lost", {28'd0, bus.hex_out}, 32'h0);
    pulse_load(32'h00000120);
    sync_fd();
`ifdef LEADING_ZERO_BLANK_EN
    frame_lit("lzb_120_lit", 8'h07);
`else
    frame_lit("lz_120_lit", 8'hFF);
`endif
    pulse_load(32'h00000000);
    sync_fd();
`ifdef LEADING_ZERO_BLANK_EN
    frame_lit("lzb_0_lit", 8'h01);
`else
    frame_lit("lz_0_lit", 8'hFF);
`endif
    sync_fd();
    step(4);
    chk("zero_digit0_seg", {24'd0, bus.segments}, 32'hC0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexing controller that shares one combinational hex-to-7-segment decoder among the eight digits of the board display. Holds a double-buffered 32-bit display value, scans one nibble per slot into the shared decoder, and drives the active-low digit-select and segment pins. Each slot starts with a guard interval to prevent ghosting. Sits between the datapath's debug/display value and the board's 7-segment pins.

## Interface
- PRESCALE_BITS, 17: each digit slot lasts 2^PRESCALE_BITS cycles.
- GUARD_CYCLES, 4096: blanked cycles at the start of each slot; legal range 1 .. 2^PRESCALE_BITS-1.
- clk  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- value  input  32  new display value; nibble i drives digit i (digit 0 rightmost).
- load  input  1  one-cycle strobe; captures value into the pending buffer.
- digit_en  input  8  per-digit enable; 0 forces that digit dark.
- hex_out  output  4  nibble presented to the shared decoder; combinational from current digit index and display buffer.
- seg_in  input  8  active-low segment pattern returned by the shared decoder for hex_out.
- digitselect  output  8  active-low digit enables, registered.
- segments  output  8  active-low segment drive, registered.
- frame_done  output  1  one-cycle pulse at each frame boundary (digit 7 → digit 0).

## Operation
- State: prescale counter cnt [PRESCALE_BITS-1:0], digit index idx [2:0], display buffer disp [31:0], pending buffer pend [31:0], pending flag pflag, phase FSM {GUARD, SHOW}.
- Phase is GUARD while cnt < GUARD_CYCLES, SHOW otherwise; it is recomputed every cycle from cnt.
- cnt increments every cycle. At cnt = all-ones it wraps to 0 and idx increments modulo 8.
- Frame boundary = cycle on which cnt wraps and idx = 7. At the boundary, if pflag is set, then disp ← pend and pflag ← 0. frame_done pulses on that same cycle.
- load: pend ← value, pflag ← 1.
- load on a frame-boundary cycle: value goes straight to disp, and pflag ← 0. Load wins; the stale pend is discarded.
- Multiple loads within a frame: the last one wins.
- hex_out = disp[4*idx +: 4] at all times, including during GUARD.
- Digit visible when phase = SHOW, digit_en[idx] = 1, and the digit is not blanked (see Configuration).
- Next-cycle outputs:
  - digit visible: digitselect ← ~(8'b1 << idx), segments ← seg_in;
  - digit not visible: digitselect ← 8'hFF, segments ← 8'hFF.
- At most one digitselect bit is ever low.
- Reset values:
  - cnt 0, idx 0, disp 0, pend 0, pflag 0;
  - digitselect 8'hFF, segments 8'hFF, frame_done 0;
  - hex_out therefore 0.
- Reset asserted mid-frame: all state returns to reset values on the next edge. A pending load is lost.

## Timing
- digitselect and segments lag the internal cnt/idx by exactly one cycle.
- Per slot: GUARD_CYCLES cycles dark, then 2^PRESCALE_BITS - GUARD_CYCLES cycles lit.
- Frame = 8·2^PRESCALE_BITS cycles. At 100 MHz with defaults: ≈1.31 ms per slot, ≈10.5 ms per frame.
- Load latency: a value loaded in frame n first appears on the outputs in slot 0 of frame n+1, one cycle after the boundary. Worst case is one frame plus one cycle.
- Decoder path: hex_out → seg_in must settle within one cycle. It is sampled on the edge following the idx change, and that edge falls inside GUARD (GUARD_CYCLES ≥ 1).
- digit_en changes take effect on the next clock edge; they are not double-buffered.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - digit i (i ≥ 1) is blanked when disp[31:4i] = 0, i.e. it is a leading zero;
  - digit 0 is never blanked;
  - blanking is evaluated against disp, not pend.
- Not defined: all enabled digits are shown, including leading zeros.

## Test plan
- Reset/scan, with PRESCALE_BITS=3, GUARD_CYCLES=2, load 32'h76543210, digit_en=8'hFF:
  - after the boundary, digitselect = 8'hFF for 2 cycles, then 8'hFE for 6 cycles, then 8'hFF for 2, then 8'hFD for 6, and so on;
  - hex_out steps 0,1,…,7;
  - segments equals the decoder pattern for each nibble while lit;
  - frame_done pulses every 64 cycles.
- Double buffering: load 32'hDEADBEEF mid-frame → disp is unchanged until the next frame_done; the following slot 0 shows nibble F.
- Load on boundary: assert load with 32'h0000000A on the frame_done cycle → digit 0 shows A in the very next slot; a prior pending value is not shown.
- Mask: digit_en = 8'b1111_0101 → digitselect never takes the values 8'hFD or 8'hF7; segments = 8'hFF during slots 1 and 3.
- Reset mid-frame: during slot 5, with a load pending, pulse reset → next cycle digitselect = 8'hFF, segments = 8'hFF, hex_out = 0; the pending value never appears.
- With LEADING_ZERO_BLANK_EN, load 32'h00000120 → only digits 0–2 light; load 32'h0 → only digit 0 lights, showing "0".
